switch_debounce_bank: RTL

//   Multi-channel debouncer for the DE4 slide switches and push buttons. It

---
 rtl/switch_debounce_if.sv | 23 ++
 rtl/switch_debounce_bank.sv | 89 ++++++++
 2 files changed

// File: rtl/switch_debounce_if.sv
// Signal bundle between the raw switch/button pads and the debouncer bank.
// The master drives the raw pads and the interrupt clears; the slave returns clean levels and events.
interface switch_debounce_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] button;
  logic [NUM_CH-1:0] irq_clear;
  logic [NUM_CH-1:0] result;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] change_pending;
  logic              change_irq;

  modport master (
    output button, irq_clear,
    input  result, rise_pulse, fall_pulse, change_pending, change_irq
  );

  modport slave (
    input  button, irq_clear,
    output result, rise_pulse, fall_pulse, change_pending, change_irq
  );
endinterface

// File: rtl/switch_debounce_bank.sv
// Multi-channel switch debouncer: 2-FF synchroniser, per-channel stability counter,
// edge pulses and a sticky change-pending interrupt for software polling.
module switch_debounce_bank #(
  parameter int                NUM_CH      = 4,
  parameter int                CLK_HZ      = 50000000,
  parameter int                DEBOUNCE_US = 10000,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  switch_debounce_if.slave  sw
);

  localparam int STABLE_CYCLES = CLK_HZ / 1000000 * DEBOUNCE_US;
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  if (STABLE_CYCLES < 1) begin : g_bad_param
    $error("switch_debounce_bank: STABLE_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0] result_vec;
  logic [NUM_CH-1:0] rise_vec;
  logic [NUM_CH-1:0] fall_vec;
  logic [NUM_CH-1:0] pend_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             res;
    logic             rise;
    logic             fall;
    logic             pend;
    logic [CNT_W-1:0] cnt;
    logic             commit;

    // The counter must reach STABLE_CYCLES before committing, which gives the
    // 2+STABLE_CYCLES edge latency from the first sync1 sample to result.
    assign commit = (sync2 != res) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= RESET_VAL[i];
        sync2 <= RESET_VAL[i];
        res   <= RESET_VAL[i];
        cnt   <= '0;
        rise  <= 1'b0;
        fall  <= 1'b0;
        pend  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments let sync2 see last cycle's sync1, forming a real 2-FF chain.
        sync1 <= sw.button[i];
        sync2 <= sync1;
        rise  <= 1'b0;
        fall  <= 1'b0;

        if (sync2 == res) begin
          cnt <= '0;
        end else if (!commit) begin
          cnt <= cnt + 1'b1;
        end else begin
          res  <= sync2;
          cnt  <= '0;
          rise <= sync2;
          fall <= ~sync2;
        end

        // A commit on the same edge as a clear wins, so no event is lost.
        if (commit) begin
          pend <= 1'b1;
        end else if (sw.irq_clear[i]) begin
          pend <= 1'b0;
        end
      end
    end

    assign result_vec[i] = res;
    assign rise_vec[i]   = rise;
    assign fall_vec[i]   = fall;
    assign pend_vec[i]   = pend;
  end

  assign sw.result         = result_vec;
  assign sw.rise_pulse     = rise_vec;
  assign sw.fall_pulse     = fall_vec;
  assign sw.change_pending = pend_vec;
  assign sw.change_irq     = |pend_vec;

endmodule
